// File: rtl/regbank_load_seq.sv
// Write sequencer feeding a regbit register array: buffers byte-pair
// writes and plays each one out as SETUP -> LOAD -> HOLD.
module regbank_load_seq #(
    parameter int NPAIRS   = 4,
    parameter int SELW     = 2,
    parameter int DEPTH    = 2,
    parameter int HOLD_CYC = 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SELW-1:0]   req_sel,
    input  logic              req_hi_en,
    input  logic              req_lo_en,
    input  logic [15:0]       req_data,
    output logic [7:0]        d_hi,
    output logic [7:0]        d_lo,
    output logic [NPAIRS-1:0] ld_hi,
    output logic [NPAIRS-1:0] ld_lo,
    output logic              busy,
    output logic              done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = SELW + 2 + 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [1:0] HLAST = 2'(HOLD_CYC - 1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;

    logic          full, empty, push, pop;
    logic [SELW-1:0] h_sel;
    logic          h_hi, h_lo;
    logic [15:0]   h_data;

    logic [1:0]      state_q, state_d;
    logic [1:0]      hcnt_q, hcnt_d;
    logic [SELW-1:0] wsel_q, wsel_d;
    logic            whi_q, whi_d;
    logic            wlo_q, wlo_d;
    logic [7:0]      dhi_q, dhi_d;
    logic [7:0]      dlo_q, dlo_d;
    logic [NPAIRS-1:0] ldh_q, ldh_d;
    logic [NPAIRS-1:0] ldl_q, ldl_d;
    logic            done_q, done_d;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = req_valid && !full;
    assign {h_sel, h_hi, h_lo, h_data} = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {req_sel, req_hi_en, req_lo_en, req_data};
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        wsel_d  = wsel_q;
        whi_d   = whi_q;
        wlo_d   = wlo_q;
        dhi_d   = dhi_q;
        dlo_d   = dlo_q;
        ldh_d   = '0;
        ldl_d   = '0;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE, S_HOLD: begin
                if (state_q == S_HOLD && hcnt_q != HLAST) begin
                    hcnt_d = hcnt_q + 2'd1;
                    done_d = (hcnt_q + 2'd1 == HLAST);
                end else begin
                    state_d = S_IDLE;
                    // Empty-enable requests are drained without a sequence
                    if (!empty) begin
                        pop = 1'b1;
                        if (h_hi || h_lo) begin
                            state_d = S_SETUP;
                            wsel_d  = h_sel;
                            whi_d   = h_hi;
                            wlo_d   = h_lo;
                            dhi_d   = h_data[15:8];
                            dlo_d   = h_data[7:0];
                        end
                    end
                end
            end
            S_SETUP: begin
                state_d = S_LOAD;
                for (int i = 0; i < NPAIRS; i++) begin
                    ldh_d[i] = whi_q && (wsel_q == SELW'(i));
                    ldl_d[i] = wlo_q && (wsel_q == SELW'(i));
                end
            end
            S_LOAD: begin
                state_d = S_HOLD;
                hcnt_d  = 2'd0;
                done_d  = (HLAST == 2'd0);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            wsel_q  <= '0;
            whi_q   <= 1'b0;
            wlo_q   <= 1'b0;
            dhi_q   <= '0;
            dlo_q   <= '0;
            ldh_q   <= '0;
            ldl_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            wsel_q  <= wsel_d;
            whi_q   <= whi_d;
            wlo_q   <= wlo_d;
            dhi_q   <= dhi_d;
            dlo_q   <= dlo_d;
            ldh_q   <= ldh_d;
            ldl_q   <= ldl_d;
            done_q  <= done_d;
        end
    end

    assign req_ready = !full;
    assign d_hi      = dhi_q;
    assign d_lo      = dlo_q;
    assign ld_hi     = ldh_q;
    assign ld_lo     = ldl_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_regbank_load_seq.sv
// Scoreboard bench for regbank_load_seq with a behavioural regbit
// array that captures d on each falling ld strobe.
module tb_regbank_load_seq;

    localparam int NP  = 4;
    localparam int HC  = 1;

    typedef struct {
        logic [1:0]  sel;
        logic        hi;
        logic        lo;
        logic [15:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_sel = '0;
    logic        req_hi_en = 1'b0;
    logic        req_lo_en = 1'b0;
    logic [15:0] req_data = '0;
    logic [7:0]  d_hi, d_lo;
    logic [NP-1:0] ld_hi, ld_lo;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ld_cyc = -100;
    int done_cnt = 0;
    int ld_log[$];
    req_t exp_q[$];

    logic [7:0] act_hi [NP];
    logic [7:0] act_lo [NP];
    logic [7:0] exp_hi [NP];
    logic [7:0] exp_lo [NP];
    logic [NP-1:0] p_ldh = '0, p_ldl = '0;
    logic [7:0] p_dhi = '0, p_dlo = '0;
    logic [7:0] held_hi = '0, held_lo = '0;
    bit saw_nr = 0;

    regbank_load_seq #(
        .NPAIRS(NP), .SELW(2), .DEPTH(2), .HOLD_CYC(HC)
    ) dut (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_hi_en(req_hi_en),
        .req_lo_en(req_lo_en), .req_data(req_data),
        .d_hi(d_hi), .d_lo(d_lo),
        .ld_hi(ld_hi), .ld_lo(ld_lo),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: regbit capture, scoreboard pop on ld, done checks
    always @(negedge clk) begin
        req_t e;
        logic [NP-1:0] eh, el;
        bit same;
        for (int i = 0; i < NP; i++) begin
            if (p_ldh[i] && !ld_hi[i]) act_hi[i] = p_dhi;
            if (p_ldl[i] && !ld_lo[i]) act_lo[i] = p_dlo;
        end
        if ((ld_hi | ld_lo) != '0) begin
            chk("ld_not_consecutive", 32'(p_ldh | p_ldl), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_ld", 32'({ld_hi, ld_lo}), 0);
            end else begin
                e = exp_q.pop_front();
                eh = e.hi ? NP'(1) << e.sel : '0;
                el = e.lo ? NP'(1) << e.sel : '0;
                chk("ld_hi", 32'(ld_hi), 32'(eh));
                chk("ld_lo", 32'(ld_lo), 32'(el));
                chk("d_at_ld", {16'h0, d_hi, d_lo}, {16'h0, e.data});
                if (e.hi) exp_hi[e.sel] = e.data[15:8];
                if (e.lo) exp_lo[e.sel] = e.data[7:0];
                held_hi = e.data[15:8];
                held_lo = e.data[7:0];
            end
            ld_log.push_back(cyc);
            ld_cyc = cyc;
        end
        if (nreset && cyc == ld_cyc + 1)
            chk("d_held", {16'h0, d_hi, d_lo}, {16'h0, held_hi, held_lo});
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_latency", 32'(cyc - ld_cyc), HC);
            same = 1;
            for (int i = 0; i < NP; i++)
                if (act_hi[i] !== exp_hi[i] || act_lo[i] !== exp_lo[i])
                    same = 0;
            chk("regbit_q_at_done", 32'(same), 1);
        end
        p_ldh = ld_hi;
        p_ldl = ld_lo;
        p_dhi = d_hi;
        p_dlo = d_lo;
    end

    // Called at a negedge; returns at the negedge after acceptance
    task automatic send(logic [1:0] s, logic h, logic l, logic [15:0] dt);
        int tmo = 0;
        req_valid = 1'b1;
        req_sel   = s;
        req_hi_en = h;
        req_lo_en = l;
        req_data  = dt;
        while (!req_ready && tmo < 100) begin
            saw_nr = 1;
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 100) chk("send_timeout", 1, 0);
        @(posedge clk);
        if (h || l) exp_q.push_back('{s, h, l, dt});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int tmo = 0;
        while ((busy || exp_q.size() != 0) && tmo < 200) begin
            @(negedge clk);
            tmo++;
        end
        if (tmo >= 200) chk("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int dc, tmo, n;
        for (int i = 0; i < NP; i++) begin
            act_hi[i] = '0; act_lo[i] = '0;
            exp_hi[i] = '0; exp_lo[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ld", 32'({ld_hi, ld_lo}), 0);
        chk("rst_d", {16'h0, d_hi, d_lo}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_ready", 32'(req_ready), 1);
        nreset = 1'b1;
        @(negedge clk);

        // Single write, both bytes
        send(2'd1, 1'b1, 1'b1, 16'hAA55);
        @(negedge clk);
        chk("setup_d", {16'h0, d_hi, d_lo}, 32'hAA55);
        chk("setup_ld", 32'({ld_hi, ld_lo}), 0);
        wait_idle();
        chk("t1_q", {16'h0, act_hi[1], act_lo[1]}, 32'hAA55);

        // Back-to-back, hi-only then lo-only
        send(2'd0, 1'b1, 1'b0, 16'h1234);
        send(2'd3, 1'b0, 1'b1, 16'hBEEF);
        wait_idle();
        n = ld_log.size();
        chk("b2b_gap", 32'(ld_log[n-1] - ld_log[n-2]), 3);
        chk("t2_q", {act_hi[0], act_lo[0], act_hi[3], act_lo[3]},
            32'h120000EF);

        // Four requests with valid held through backpressure
        dc = done_cnt;
        saw_nr = 0;
        send(2'd1, 1'b0, 1'b1, 16'h0102);
        send(2'd2, 1'b1, 1'b1, 16'h0304);
        send(2'd3, 1'b1, 1'b0, 16'h0506);
        send(2'd1, 1'b1, 1'b0, 16'h0708);
        wait_idle();
        chk("backpressure_seen", 32'(saw_nr), 1);
        chk("t3_dones", 32'(done_cnt - dc), 4);
        chk("t3_q", {act_hi[1], act_lo[1], act_hi[2], act_lo[2]},
            32'h07020304);

        // Reset during LOAD with one more request queued
        send(2'd2, 1'b1, 1'b1, 16'hC3A5);
        send(2'd0, 1'b1, 1'b1, 16'h7777);
        tmo = 0;
        while ((ld_hi | ld_lo) == '0 && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        chk("t4_ld_seen", 32'(tmo < 20), 1);
        #1;
        nreset = 1'b0;
        exp_q.delete();
        dc = done_cnt;
        @(negedge clk);
        chk("t4_ld_dropped", 32'({ld_hi, ld_lo}), 0);
        chk("t4_ready_busy", {req_ready, busy}, 32'b10);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (8) @(negedge clk);
        chk("t4_no_done", 32'(done_cnt - dc), 0);
        chk("t4_queued_dropped", {act_hi[0], act_lo[0]}, 32'h1200);

        // No-enable request is drained silently
        dc = done_cnt;
        n = ld_log.size();
        send(2'd2, 1'b0, 1'b0, 16'hFFFF);
        chk("t5_busy_acc", 32'(busy), 1);
        @(negedge clk);
        chk("t5_busy_clear", 32'(busy), 0);
        repeat (4) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt - dc), 0);
        chk("t5_no_ld", 32'(ld_log.size() - n), 0);

        for (int i = 0; i < NP; i++) begin
            chk("final_q_hi", 32'(act_hi[i]), 32'(exp_hi[i]));
            chk("final_q_lo", 32'(act_lo[i]), 32'(exp_lo[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
